// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one access at a time over a req/ready + rvalid
// data-memory handshake, with load extension, store lane steering, alignment
// and size checking, and a bounded wait for the memory.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_valid,
  input  logic                  op_store,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] op_addr,
  input  logic [31:0]           op_wdata,
  output logic                  stall,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           load_data,
  output logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    store_q, store_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [1:0]              lo_q, lo_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    done_d, err_d, mem_req_d, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_d;
  logic [31:0]             mem_wdata_d, load_data_d;
  logic [3:0]              mem_wstrb_d;

  logic                    illegal, misaligned, timeout_hit;
  logic [31:0]             rd_shift, rd_ext;

  // Size/alignment checks on the incoming op; H and HU share funct3[1:0]=01.
  always_comb begin
    if (op_store) illegal = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
    else          illegal = (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
    misaligned = (funct3[1:0] == 2'b01 && op_addr[0]) ||
                 (funct3[1:0] == 2'b10 && op_addr[1:0] != 2'b00);
  end

  // Pick the addressed byte/half from the read word and extend it.
  always_comb begin
    rd_shift = mem_rdata >> {lo_q, 3'b000};
    case (funct3_q)
      3'b000:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  rd_ext = {24'h0, rd_shift[7:0]};
      3'b001:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b101:  rd_ext = {16'h0, rd_shift[15:0]};
      default: rd_ext = mem_rdata;
    endcase
  end

  assign timeout_hit = (cnt_q + CNT_W'(1)) == TIMEOUT_CNT;

  // Next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    funct3_d    = funct3_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_wstrb_d = mem_wstrb;
    load_data_d = load_data;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          store_d    = op_store;
          funct3_d   = funct3;
          lo_d       = op_addr[1:0];
          cnt_d      = '0;
          mem_addr_d = {op_addr[ADDR_WIDTH-1:2], 2'b00};
          case (funct3[1:0])
            2'b00: begin
              mem_wstrb_d = 4'b0001 << op_addr[1:0];
              mem_wdata_d = {4{op_wdata[7:0]}};
            end
            2'b01: begin
              mem_wstrb_d = 4'b0011 << op_addr[1:0];
              mem_wdata_d = {2{op_wdata[15:0]}};
            end
            default: begin
              mem_wstrb_d = 4'b1111;
              mem_wdata_d = op_wdata;
            end
          endcase
          if (illegal || misaligned) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_ready) begin
          state_d = store_q ? DONE : WAIT;
          cnt_d   = cnt_q + CNT_W'(1);
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          load_data_d = rd_ext;
          state_d     = DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d    = (state_d == DONE);
    mem_req_d = (state_d == REQ);
    mem_we_d  = (state_d == REQ) && store_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      store_q   <= 1'b0;
      funct3_q  <= 3'b000;
      lo_q      <= 2'b00;
      cnt_q     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      load_data <= '0;
    end else begin
      state_q   <= state_d;
      store_q   <= store_d;
      funct3_q  <= funct3_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      done      <= done_d;
      err       <= err_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_wstrb <= mem_wstrb_d;
      load_data <= load_data_d;
    end
  end

  // Hold upstream while an op is being taken or is outstanding.
  assign stall = (state_q == IDLE && op_valid) || state_q == REQ || state_q == WAIT;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; a second instance with TIMEOUT=4 covers the abort path.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n, op_valid, op_store, mem_ready, mem_rvalid;
  logic [2:0]  funct3;
  logic [31:0] op_addr, op_wdata, mem_rdata;
  logic        stall, done, err, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        t_stall, t_done, t_err, t_mem_req, t_mem_we;
  logic [31:0] t_load_data, t_mem_addr, t_mem_wdata;
  logic [3:0]  t_mem_wstrb;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_store(op_store), .funct3(funct3),
    .op_addr(op_addr), .op_wdata(op_wdata), .stall(stall), .done(done), .err(err),
    .load_data(load_data), .mem_req(mem_req), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));

  load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT(4)) dut_t (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_store(op_store), .funct3(funct3),
    .op_addr(op_addr), .op_wdata(op_wdata), .stall(t_stall), .done(t_done), .err(t_err),
    .load_data(t_load_data), .mem_req(t_mem_req), .mem_ready(mem_ready), .mem_we(t_mem_we),
    .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata), .mem_wstrb(t_mem_wstrb),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic set_op(input logic v, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    op_valid = v; op_store = st; funct3 = f3; op_addr = a; op_wdata = wd;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    apply_reset;
    #1;
    checks++; if ({stall, done, err, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, load_data} !== '0) begin
      errors++; $display("FAIL reset_outputs got stall=%0b done=%0b err=%0b req=%0b we=%0b addr=%h wdata=%h wstrb=%b ld=%h exp all 0",
                         stall, done, err, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, load_data); end
  endtask

  task automatic test_store;
    apply_reset;
    // SB to the top byte lane, zero-wait memory
    tick; set_op(1'b1, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB); mem_ready = 1'b1; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_stall_c0 got=%0b exp=1", stall); end
    tick; op_valid = 1'b0; #1;
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL sb_req_c1 got req=%0b we=%0b exp 1 1", mem_req, mem_we); end
    checks++; if (mem_addr !== 32'h0000_1000) begin errors++; $display("FAIL sb_addr got=%h exp=00001000", mem_addr); end
    checks++; if (mem_wstrb !== 4'b1000) begin errors++; $display("FAIL sb_wstrb got=%b exp=1000", mem_wstrb); end
    checks++; if (mem_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata got=%h exp=abababab", mem_wdata); end
    checks++; if (stall !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL sb_c1_stall_done got stall=%0b done=%0b exp 1 0", stall, done); end
    tick; #1;
    checks++; if (done !== 1'b1 || err !== 1'b0 || mem_req !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL sb_done_c2 got done=%0b err=%0b req=%0b stall=%0b exp 1 0 0 0", done, err, mem_req, stall); end
    tick; #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL sb_done_pulse got=%0b exp=0", done); end
    // SH to the upper half
    tick; set_op(1'b1, 1'b1, 3'b001, 32'h0000_1002, 32'h0000_1234); #1;
    tick; op_valid = 1'b0; #1;
    checks++; if (mem_wstrb !== 4'b1100 || mem_wdata !== 32'h1234_1234) begin
      errors++; $display("FAIL sh_lanes got wstrb=%b wdata=%h exp 1100 12341234", mem_wstrb, mem_wdata); end
    tick; tick;
    // store with load-only size code is illegal
    tick; set_op(1'b1, 1'b1, 3'b100, 32'h0000_1000, 32'h0); #1;
    tick; op_valid = 1'b0; #1;
    checks++; if (done !== 1'b1 || err !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL st_illegal got done=%0b err=%0b req=%0b exp 1 1 0", done, err, mem_req); end
    tick;
  endtask

  // LB/LBU at 0x2001: accept at cycle 3, rvalid at cycle 6, result at cycle 7.
  task automatic run_load(input logic [2:0] f3, input logic [31:0] exp_ld, input string nm);
    tick; set_op(1'b1, 1'b0, f3, 32'h0000_2001, 32'h0); mem_ready = 1'b0; #1;
    for (int c = 1; c <= 7; c++) begin
      tick;
      op_valid   = 1'b0;
      mem_ready  = (c == 3);
      mem_rvalid = (c == 6);
      mem_rdata  = (c == 6) ? 32'h0000_80FF : 32'h0;
      #1;
      if (c <= 3) begin
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL %s_req_c%0d got=%0b exp=1", nm, c, mem_req); end
      end
      if (c == 5) begin
        checks++; if (stall !== 1'b1 || mem_req !== 1'b0 || done !== 1'b0) begin
          errors++; $display("FAIL %s_wait got stall=%0b req=%0b done=%0b exp 1 0 0", nm, stall, mem_req, done); end
      end
      if (c == 7) begin
        checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL %s_done got done=%0b err=%0b exp 1 0", nm, done, err); end
        checks++; if (load_data !== exp_ld) begin errors++; $display("FAIL %s_data got=%h exp=%h", nm, load_data, exp_ld); end
      end
    end
    mem_rvalid = 1'b0;
    tick;
  endtask

  task automatic test_load;
    apply_reset;
    run_load(3'b000, 32'hFFFF_FF80, "lb");
    run_load(3'b100, 32'h0000_0080, "lbu");
  endtask

  task automatic test_misaligned;
    logic saw_req;
    saw_req = 1'b0;
    tick; set_op(1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'h0); mem_ready = 1'b1; #1;
    saw_req = saw_req | mem_req;
    tick; op_valid = 1'b0; #1;
    saw_req = saw_req | mem_req;
    checks++; if (done !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL lw_mis_done got done=%0b err=%0b exp 1 1", done, err); end
    checks++; if (load_data !== 32'h0000_0080) begin errors++; $display("FAIL lw_mis_ld got=%h exp=00000080", load_data); end
    tick; #1; saw_req = saw_req | mem_req;
    tick; #1; saw_req = saw_req | mem_req;
    checks++; if (saw_req !== 1'b0) begin errors++; $display("FAIL lw_mis_noreq got=%0b exp=0", saw_req); end
  endtask

  task automatic test_timeout;
    apply_reset;
    tick; set_op(1'b1, 1'b0, 3'b001, 32'h0000_4000, 32'h0); mem_ready = 1'b0; #1;
    for (int c = 1; c <= 4; c++) begin
      tick; op_valid = 1'b0; #1;
      checks++; if (t_mem_req !== 1'b1 || t_done !== 1'b0) begin
        errors++; $display("FAIL to_req_c%0d got req=%0b done=%0b exp 1 0", c, t_mem_req, t_done); end
    end
    tick; #1;
    checks++; if (t_done !== 1'b1 || t_err !== 1'b1 || t_mem_req !== 1'b0) begin
      errors++; $display("FAIL to_abort got done=%0b err=%0b req=%0b exp 1 1 0", t_done, t_err, t_mem_req); end
    checks++; if (t_load_data !== 32'h0) begin errors++; $display("FAIL to_ld got=%h exp=0", t_load_data); end
  endtask

  // LW 0x10 then SW 0x14; upstream holds each op until the DONE cycle.
  // The load takes 4 cycles (0-3) and the store 3 (4-6), so done pulses land at 3 and 6.
  task automatic test_back_to_back;
    logic [7:0] exp_stall, exp_done;
    exp_stall = 8'b0011_0111;  // bit c = cycle c
    exp_done  = 8'b0100_1000;
    apply_reset;
    mem_ready = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      tick;
      if (c <= 3)      set_op(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0);
      else if (c <= 6) set_op(1'b1, 1'b1, 3'b010, 32'h0000_0014, 32'h55AA_55AA);
      else             op_valid = 1'b0;
      mem_rvalid = (c == 2) || (c == 5);
      mem_rdata  = (c == 2) ? 32'hCAFE_F00D : 32'hDEAD_BEEF;
      #1;
      checks++; if (stall !== exp_stall[c] || done !== exp_done[c]) begin
        errors++; $display("FAIL b2b_c%0d got stall=%0b done=%0b exp %0b %0b", c, stall, done, exp_stall[c], exp_done[c]); end
      if (c == 5) begin
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h14 || mem_wstrb !== 4'b1111 || mem_wdata !== 32'h55AA_55AA) begin
          errors++; $display("FAIL b2b_sw got we=%0b addr=%h wstrb=%b wdata=%h exp 1 00000014 1111 55aa55aa", mem_we, mem_addr, mem_wstrb, mem_wdata); end
      end
      if (c == 6) begin
        checks++; if (load_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_ld got=%h exp=cafef00d", load_data); end
      end
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic test_reset_mid_wait;
    apply_reset;
    tick; set_op(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0); mem_ready = 1'b1; #1;
    tick; op_valid = 1'b0; #1;
    tick; mem_ready = 1'b0; #1;
    checks++; if (stall !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL rmw_in_wait got stall=%0b req=%0b exp 1 0", stall, mem_req); end
    #2 rst_n = 1'b0; #1;
    checks++; if ({stall, done, err, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, load_data} !== '0) begin
      errors++; $display("FAIL rmw_async got stall=%0b done=%0b req=%0b addr=%h ld=%h exp all 0", stall, done, mem_req, mem_addr, load_data); end
    tick; tick;
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    for (int c = 0; c < 3; c++) begin
      tick; #1;
      checks++; if (done !== 1'b0 || stall !== 1'b0 || mem_req !== 1'b0 || load_data !== 32'h0) begin
        errors++; $display("FAIL rmw_late_rvalid_%0d got done=%0b stall=%0b req=%0b ld=%h exp 0 0 0 0", c, done, stall, mem_req, load_data); end
    end
    mem_rvalid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_store;
    test_load;
    test_misaligned;
    test_timeout;
    test_back_to_back;
    test_reset_mid_wait;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1);
  end
endmodule
